// File: rtl/phase_sampler_pkg.sv
// phase_sampler_pkg: bus decode constants (address tag and register word offsets) shared by the sampler and its bench
package phase_sampler_pkg;
  localparam logic [7:0] SAMPLER_ADDR_MASK = 8'h43;
  localparam logic [9:0] REG_CTRL          = 10'h000;
  localparam logic [9:0] REG_SETTLE        = 10'h001;
  localparam logic [9:0] REG_MEASURE       = 10'h002;
  localparam logic [9:0] REG_SPINS         = 10'h004;
  localparam logic [9:0] REG_PHASE         = 10'h010;
endpackage

// File: rtl/phase_sampler_counter.sv
// phase_counter: saturating up-counter with synchronous clear and enable; also exposes its next value
module phase_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_d_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d   = clr_i ? '0 : (en_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/phase_sampler.sv
// phase_sampler: kicks a coupled oscillator array, counts per-spin phase agreement with spin 0, reports majority spins.
// Define SAMPLER_SYNC_EN to put 2-flop synchronizers on external_spin (settle is stretched to flush them).
module phase_sampler
  import phase_sampler_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         axi_rst,
  input  logic [N-1:0] external_spin,
  output logic         ising_rstn,
  input  logic         wready,
  input  logic [31:0]  wr_addr,
  input  logic [31:0]  wdata,
  input  logic [31:0]  rd_addr,
  output logic [31:0]  rdata,
  output logic         done
);
  typedef enum logic [2:0] {IDLE, KICK, SETTLE, MEASURE, DONE} state_t;
  localparam int W = CNT_W > 32 ? CNT_W : 32;
  logic [N-1:0] spin_s;
`ifdef SAMPLER_SYNC_EN
  localparam logic [31:0] SYNC_LAT = 32'd2;
  logic [N-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk) begin
    if (axi_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= external_spin;
      sync2_q <= sync1_q;
    end
  end
  assign spin_s = sync2_q;
`else
  localparam logic [31:0] SYNC_LAT = 32'd0;
  assign spin_s = external_spin;
`endif
  state_t       state_q, state_d;
  logic [31:0]  timer_q, timer_d, settle_q, settle_d, measure_q, measure_d;
  logic [31:0]  settle_run_q, settle_run_d, measure_run_q, measure_run_d;
  logic [31:0]  settle_lat, rdata_q, rdata_d;
  logic [N-1:0] spins_q, spins_d;
  logic         done_q, done_d, busy, clr, en, wr_hit, start;
  logic [9:0]   wr_off, rd_off;
  logic [CNT_W-1:0] cnt [N];
  logic [CNT_W-1:0] cnt_nx [N];
  logic unused;
  assign unused     = ^{wr_addr[23:12], wr_addr[1:0], rd_addr[23:12], rd_addr[1:0]};
  assign wr_off     = wr_addr[11:2];
  assign rd_off     = rd_addr[11:2];
  assign wr_hit     = wready && wr_addr[31:24] == SAMPLER_ADDR_MASK;
  assign start      = wr_hit && wr_off == REG_CTRL && wdata[0];
  assign settle_d   = wr_hit && wr_off == REG_SETTLE ? wdata : settle_q;
  assign measure_d  = wr_hit && wr_off == REG_MEASURE ? wdata : measure_q;
  assign settle_lat = settle_run_q + SYNC_LAT;
  assign busy       = state_q inside {KICK, SETTLE, MEASURE};
  assign ising_rstn = state_q inside {SETTLE, MEASURE, DONE};
  assign done       = done_q;
  assign rdata      = rdata_q;
  genvar g;
  for (g = 0; g < N; g++) begin : g_cnt
    phase_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (axi_rst),
      .clr_i  (clr),
      .en_i   (en && spin_s[g] == spin_s[0]),
      .cnt_o  (cnt[g]),
      .cnt_d_o(cnt_nx[g])
    );
  end
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    spins_d       = spins_q;
    done_d        = done_q;
    settle_run_d  = settle_run_q;
    measure_run_d = measure_run_q;
    clr           = 1'b0;
    en            = 1'b0;
    if (start) begin
      state_d       = KICK;
      clr           = 1'b1;
      spins_d       = '0;
      done_d        = 1'b0;
      settle_run_d  = settle_q;
      measure_run_d = measure_q;
    end else begin
      case (state_q)
        KICK: begin
          state_d = settle_lat == '0 ? MEASURE : SETTLE;
          timer_d = settle_lat == '0 ? measure_run_q : settle_lat;
        end
        SETTLE: begin
          state_d = timer_q == 32'd1 ? MEASURE : SETTLE;
          timer_d = timer_q == 32'd1 ? measure_run_q : timer_q - 32'd1;
        end
        MEASURE: begin
          // a zero-length window still spends one cycle here, with counting suppressed
          en      = timer_q != '0;
          timer_d = en ? timer_q - 32'd1 : timer_q;
          if (timer_q <= 32'd1) begin
            state_d = DONE;
            done_d  = 1'b1;
            for (int i = 0; i < N; i++) spins_d[i] = W'(cnt_nx[i]) > W'(measure_run_q >> 1);
          end
        end
        default: ;
      endcase
    end
  end
  always_comb begin
    rdata_d = '0;
    if (rd_addr[31:24] == SAMPLER_ADDR_MASK) begin
      rdata_d = rd_off == REG_CTRL    ? {30'b0, busy, done_q} :
                rd_off == REG_SETTLE  ? settle_q :
                rd_off == REG_MEASURE ? measure_q :
                rd_off == REG_SPINS   ? 32'(spins_q) : '0;
      for (int i = 0; i < N; i++) if (rd_off == 10'(REG_PHASE + i)) rdata_d = 32'(cnt[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (axi_rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      settle_q      <= '0;
      measure_q     <= '0;
      settle_run_q  <= '0;
      measure_run_q <= '0;
      spins_q       <= '0;
      done_q        <= 1'b0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      settle_q      <= settle_d;
      measure_q     <= measure_d;
      settle_run_q  <= settle_run_d;
      measure_run_q <= measure_run_d;
      spins_q       <= spins_d;
      done_q        <= done_d;
      rdata_q       <= rdata_d;
    end
  end
endmodule

// File: tb/tb_phase_sampler.sv
// tb_phase_sampler: directed scenarios for phase_sampler with hand-computed expectations
module tb_phase_sampler;
  import phase_sampler_pkg::*;
  localparam int N = 8;
  logic clk = 1'b0, axi_rst = 1'b1, wready = 1'b0, ph = 1'b0, ising_rstn, done;
  logic [N-1:0] anti = '0, external_spin;
  logic [31:0] wr_addr = '0, wdata = '0, rd_addr = '0, rdata, d;
  int tests = 0, fails = 0, cyc;
  always #5 clk = ~clk;
  always @(posedge clk) ph <= ~ph;
  assign external_spin = {N{ph}} ^ anti;
  phase_sampler #(.N(N), .CNT_W(32)) dut (
    .clk          (clk),
    .axi_rst      (axi_rst),
    .external_spin(external_spin),
    .ising_rstn   (ising_rstn),
    .wready       (wready),
    .wr_addr      (wr_addr),
    .wdata        (wdata),
    .rd_addr      (rd_addr),
    .rdata        (rdata),
    .done         (done)
  );
  function automatic logic [31:0] ra(input logic [9:0] off);
    return {SAMPLER_ADDR_MASK, 12'h000, off, 2'b00};
  endfunction
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wr(input logic [9:0] off, input logic [31:0] v);
    wready = 1'b1;
    wr_addr = ra(off);
    wdata = v;
    step(1);
    wready = 1'b0;
  endtask
  task automatic rd_raw(input logic [31:0] a, output logic [31:0] v);
    rd_addr = a;
    step(1);
    v = rdata;
  endtask
  task automatic rd(input logic [9:0] off, output logic [31:0] v);
    rd_raw(ra(off), v);
  endtask
  task automatic wait_done(output int c);
    c = 0;
    while (done !== 1'b1 && c < 400) begin
      step(1);
      c++;
    end
  endtask
  task automatic test_reset;
    step(2);
    axi_rst = 1'b0;
    tests++; if (rdata !== 32'd0) begin fails++; $display("FAIL reset_rdata got %0h want 0", rdata); end
    tests++; if (ising_rstn !== 1'b0) begin fails++; $display("FAIL reset_rstn got %b want 0", ising_rstn); end
    rd(REG_CTRL, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL reset_status got %0h want 0", d); end
    axi_rst = 1'b1;
    wready = 1'b1; wr_addr = ra(REG_CTRL); wdata = 32'd1;
    step(1);
    axi_rst = 1'b0; wready = 1'b0;
    tests++; if (ising_rstn !== 1'b0) begin fails++; $display("FAIL reset_vs_start_rstn got %b want 0", ising_rstn); end
    rd(REG_CTRL, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL reset_vs_start_status got %0h want 0", d); end
  endtask
  task automatic test_in_phase;
    anti = '0;
    wr(REG_SETTLE, 32'd4);
    wr(REG_MEASURE, 32'd100);
    wr(REG_CTRL, 32'd1);
    tests++; if (ising_rstn !== 1'b0) begin fails++; $display("FAIL kick_rstn got %b want 0", ising_rstn); end
    wait_done(cyc);
    tests++; if (cyc !== 105) begin fails++; $display("FAIL in_phase_latency got %0d want 105", cyc); end
    tests++; if (ising_rstn !== 1'b1) begin fails++; $display("FAIL done_rstn got %b want 1", ising_rstn); end
    for (int i = 0; i < N; i++) begin
      rd(REG_PHASE + 10'(i), d);
      tests++; if (d !== 32'd100) begin fails++; $display("FAIL in_phase_cnt%0d got %0d want 100", i, d); end
    end
    rd(REG_SPINS, d);
    tests++; if (d !== 32'hFF) begin fails++; $display("FAIL in_phase_spins got %0h want ff", d); end
    rd(REG_CTRL, d);
    tests++; if (d !== 32'd1) begin fails++; $display("FAIL done_status got %0h want 1", d); end
    rd_raw({8'h00, 12'h000, REG_PHASE, 2'b00}, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL bad_tag_read got %0h want 0", d); end
    rd(10'h003, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL unmapped_read got %0h want 0", d); end
  endtask
  task automatic test_antiphase;
    anti = 8'h08;
    wr(REG_CTRL, 32'd1);
    wait_done(cyc);
    tests++; if (cyc !== 105) begin fails++; $display("FAIL anti_latency got %0d want 105", cyc); end
    rd(REG_PHASE + 10'd3, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL anti_cnt3 got %0d want 0", d); end
    rd(REG_PHASE, d);
    tests++; if (d !== 32'd100) begin fails++; $display("FAIL anti_cnt0 got %0d want 100", d); end
    rd(REG_SPINS, d);
    tests++; if (d !== 32'hF7) begin fails++; $display("FAIL anti_spins got %0h want f7", d); end
    anti = '0;
  endtask
  task automatic test_restart;
    wr(REG_CTRL, 32'd1);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL start_clears_done got %b want 0", done); end
    step(54);
    rd(REG_PHASE + 10'd1, d);
    tests++; if (d !== 32'd49) begin fails++; $display("FAIL mid_cnt got %0d want 49", d); end
    wr(REG_CTRL, 32'd1);
    tests++; if (ising_rstn !== 1'b0) begin fails++; $display("FAIL abort_rstn got %b want 0", ising_rstn); end
    rd(REG_PHASE + 10'd1, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL abort_cleared got %0d want 0", d); end
    tests++; if (ising_rstn !== 1'b1) begin fails++; $display("FAIL abort_pulse_len got %b want 1", ising_rstn); end
    wait_done(cyc);
    tests++; if (cyc !== 104) begin fails++; $display("FAIL restart_latency got %0d want 104", cyc); end
    rd(REG_PHASE + 10'd6, d);
    tests++; if (d !== 32'd100) begin fails++; $display("FAIL restart_cnt got %0d want 100", d); end
    rd(REG_SPINS, d);
    tests++; if (d !== 32'hFF) begin fails++; $display("FAIL restart_spins got %0h want ff", d); end
  endtask
  task automatic test_config_while_busy;
    wr(REG_CTRL, 32'd1);
    wr(REG_MEASURE, 32'd20);
    wait_done(cyc);
    tests++; if (cyc !== 104) begin fails++; $display("FAIL busy_cfg_latency got %0d want 104", cyc); end
    rd(REG_PHASE + 10'd5, d);
    tests++; if (d !== 32'd100) begin fails++; $display("FAIL busy_cfg_cnt got %0d want 100", d); end
    rd(REG_MEASURE, d);
    tests++; if (d !== 32'd20) begin fails++; $display("FAIL busy_cfg_stored got %0d want 20", d); end
    wr(REG_CTRL, 32'd1);
    wait_done(cyc);
    tests++; if (cyc !== 25) begin fails++; $display("FAIL new_cfg_latency got %0d want 25", cyc); end
    rd(REG_PHASE + 10'd2, d);
    tests++; if (d !== 32'd20) begin fails++; $display("FAIL new_cfg_cnt got %0d want 20", d); end
  endtask
  task automatic test_measure_zero;
    wr(REG_SETTLE, 32'd0);
    wr(REG_MEASURE, 32'd0);
    wr(REG_CTRL, 32'd1);
    wait_done(cyc);
    tests++; if (cyc !== 2) begin fails++; $display("FAIL m0_latency got %0d want 2", cyc); end
    rd(REG_SPINS, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL m0_spins got %0h want 0", d); end
    rd(REG_PHASE, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL m0_cnt got %0d want 0", d); end
  endtask
  task automatic test_settle_zero;
    wr(REG_MEASURE, 32'd10);
    wr(REG_CTRL, 32'd1);
    wait_done(cyc);
    tests++; if (cyc !== 11) begin fails++; $display("FAIL s0_latency got %0d want 11", cyc); end
    rd(REG_PHASE + 10'd7, d);
    tests++; if (d !== 32'd10) begin fails++; $display("FAIL s0_cnt got %0d want 10", d); end
  endtask
  task automatic test_reset_mid;
    wr(REG_SETTLE, 32'd4);
    wr(REG_MEASURE, 32'd100);
    wr(REG_CTRL, 32'd1);
    step(2);
    axi_rst = 1'b1;
    step(1);
    axi_rst = 1'b0;
    tests++; if (ising_rstn !== 1'b0) begin fails++; $display("FAIL rst_mid_rstn got %b want 0", ising_rstn); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_mid_done got %b want 0", done); end
    rd(REG_CTRL, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL rst_mid_status got %0h want 0", d); end
    rd(REG_SETTLE, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL rst_mid_settle got %0d want 0", d); end
    rd(REG_MEASURE, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL rst_mid_measure got %0d want 0", d); end
    rd(REG_SPINS, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL rst_mid_spins got %0h want 0", d); end
  endtask
  initial begin
    test_reset;
    test_in_phase;
    test_antiphase;
    test_restart;
    test_config_while_busy;
    test_measure_zero;
    test_settle_zero;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
